// File: rtl/ex_stage_ctrl_if.sv
// Bundle of the ID-side handshake, the MEM-side handshake and the exec-stage
// control/resolution signals seen by ex_stage_ctrl. Branch stats ports exist only with EX_BRANCH_STATS_EN.
interface ex_stage_ctrl_if;
  // valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, ready may depend on valid's partner state.
  logic        id_valid;
  logic        id_ready;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;
  logic        mem_ready;
  logic        b_sel;
  logic [31:0] sum;
  logic        ex_valid;
  logic [3:0]  ALUoperation;
  logic        ALUSrc;
  logic        Branch;
  logic        illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
`ifdef EX_BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] br_taken_count;

  modport master (
    output id_valid, id_opcode, id_funct3, id_funct7_5, mem_ready, b_sel, sum,
    input  id_ready, ex_valid, ALUoperation, ALUSrc, Branch, illegal,
           redirect_valid, redirect_pc, flush, br_count, br_taken_count
  );

  modport slave (
    input  id_valid, id_opcode, id_funct3, id_funct7_5, mem_ready, b_sel, sum,
    output id_ready, ex_valid, ALUoperation, ALUSrc, Branch, illegal,
           redirect_valid, redirect_pc, flush, br_count, br_taken_count
  );
`else
  modport master (
    output id_valid, id_opcode, id_funct3, id_funct7_5, mem_ready, b_sel, sum,
    input  id_ready, ex_valid, ALUoperation, ALUSrc, Branch, illegal,
           redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  id_valid, id_opcode, id_funct3, id_funct7_5, mem_ready, b_sel, sum,
    output id_ready, ex_valid, ALUoperation, ALUSrc, Branch, illegal,
           redirect_valid, redirect_pc, flush
  );
`endif
endinterface

// File: rtl/ex_stage_ctrl.sv
// Execute-stage control sequencer: EX control register, branch redirect and wrong-path flush.
// Optional branch statistics counters are enabled by defining EX_BRANCH_STATS_EN.
module ex_stage_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  ex_stage_ctrl_if.slave bus,
  output logic           dbg_state,
  output logic [3:0]     dbg_flush_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ex_valid_q, ex_valid_d;
  logic [3:0]  alu_q, alu_d;
  logic        src_q, src_d;
  logic        br_q, br_d;
  logic        ill_q, ill_d;
  logic        redir_v_q, redir_v_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        retire;
  logic        id_ready;
  logic        accept;
  logic        taken;
  logic        load;

  logic [3:0]  dec_alu;
  logic        dec_src;
  logic        dec_br;
  logic        dec_ill;
  logic [3:0]  f3_alu;
  logic        f3_ill;

  // Handshake and branch resolution
  assign retire   = ex_valid_q && bus.mem_ready;
  assign id_ready = (state_q == ST_FLUSH) || !ex_valid_q || bus.mem_ready;
  assign accept   = bus.id_valid && id_ready;
  assign taken    = (state_q == ST_RUN) && retire && br_q && bus.b_sel;
  assign load     = (state_q == ST_RUN) && accept && !taken;

  // funct3 map shared by R-type and I-type arithmetic
  always_comb begin
    f3_alu = ALU_ADD;
    f3_ill = 1'b0;
    case (bus.id_funct3)
      3'b000:  f3_alu = ALU_ADD;
      3'b111:  f3_alu = ALU_AND;
      3'b110:  f3_alu = ALU_OR;
      3'b100:  f3_alu = ALU_XOR;
      3'b010:  f3_alu = ALU_SLT;
      default: f3_ill = 1'b1;
    endcase
  end

  always_comb begin
    dec_alu = ALU_ADD;
    dec_src = 1'b1;
    dec_br  = 1'b0;
    dec_ill = 1'b0;
    case (bus.id_opcode)
      OP_R: begin
        dec_src = 1'b1;
        dec_ill = f3_ill;
        dec_alu = f3_alu;
        if (bus.id_funct3 == 3'b000 && bus.id_funct7_5) begin
          dec_alu = ALU_SUB;
        end
      end
      OP_I: begin
        dec_src = 1'b0;
        dec_ill = f3_ill;
        dec_alu = f3_alu;
      end
      OP_LOAD, OP_STORE: begin
        dec_src = 1'b0;
        dec_alu = ALU_ADD;
      end
      OP_BRANCH: begin
        dec_src = 1'b1;
        dec_br  = 1'b1;
        dec_alu = ALU_SUB;
        dec_ill = (bus.id_funct3 != 3'b000);
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= 4'd0;
      ex_valid_q <= 1'b0;
      alu_q      <= ALU_ADD;
      src_q      <= 1'b1;
      br_q       <= 1'b0;
      ill_q      <= 1'b0;
      redir_v_q  <= 1'b0;
      redir_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
      alu_q      <= alu_d;
      src_q      <= src_d;
      br_q       <= br_d;
      ill_q      <= ill_d;
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  // Next-state logic; the counter leaving 1 ends the flush window
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (taken) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      ST_FLUSH: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // EX control register and redirect updates
  always_comb begin
    ex_valid_d = ex_valid_q;
    alu_d      = alu_q;
    src_d      = src_q;
    br_d       = br_q;
    ill_d      = ill_q;
    redir_v_d  = taken;
    redir_pc_d = redir_pc_q;
    if (taken) begin
      redir_pc_d = bus.sum;
    end
    if (load) begin
      ex_valid_d = 1'b1;
      alu_d      = dec_alu;
      src_d      = dec_src;
      br_d       = dec_br;
      ill_d      = dec_ill;
    end else if (taken || retire) begin
      ex_valid_d = 1'b0;
    end
  end

  assign bus.id_ready       = id_ready;
  assign bus.ex_valid       = ex_valid_q;
  assign bus.ALUoperation   = alu_q;
  assign bus.ALUSrc         = src_q;
  assign bus.Branch         = br_q;
  assign bus.illegal        = ill_q;
  assign bus.redirect_valid = redir_v_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.flush          = (state_q == ST_FLUSH);
  assign dbg_state          = (state_q == ST_FLUSH);
  assign dbg_flush_cnt      = cnt_q;

`ifdef EX_BRANCH_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] tk_cnt_q, tk_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_cnt_q <= 32'd0;
      tk_cnt_q <= 32'd0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  // Counters wrap naturally at 32 bits
  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (retire && br_q) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (bus.b_sel) begin
        tk_cnt_d = tk_cnt_q + 32'd1;
      end
    end
  end

  assign bus.br_count       = br_cnt_q;
  assign bus.br_taken_count = tk_cnt_q;
`endif

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Bench for ex_stage_ctrl: decode vector table, hand-written branch/stall/reset
// sequences, then randomized traffic against a cycle-level reference model.
module tb_ex_stage_ctrl;

  localparam int FC = 2;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic       clk;
  logic       reset;
  logic       dbg_state;
  logic [3:0] dbg_flush_cnt;

  ex_stage_ctrl_if bus();

  ex_stage_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .dbg_state     (dbg_state),
    .dbg_flush_cnt (dbg_flush_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vectors;
  int n_miscompares;

  typedef struct packed {
    logic [3:0] alu;
    logic       src;
    logic       br;
    logic       ill;
  } ctl_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    ctl_t       exp;
  } dec_vec_t;

  // ---------------- reference model ----------------
  logic [3:0]  f3_alu [8];
  logic [7:0]  f3_legal;
  logic        m_ev;
  ctl_t        m_ctl;
  logic        m_rv;
  logic [31:0] m_rpc;
  int          m_flush_left;
  logic [31:0] m_brc;
  logic [31:0] m_tkc;

  function automatic ctl_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    ctl_t c;
    c = '{alu: 4'b0010, src: 1'b1, br: 1'b0, ill: 1'b0};
    if (op == OP_R || op == OP_I) begin
      c.alu = f3_alu[f3];
      c.ill = !f3_legal[f3];
      c.src = (op == OP_R);
      if (op == OP_R && f3 == 3'b000 && f7) c.alu = 4'b0110;
    end else if (op == OP_LOAD || op == OP_STORE) begin
      c.src = 1'b0;
    end else if (op == OP_BRANCH) begin
      c.alu = 4'b0110;
      c.br  = 1'b1;
      c.ill = (f3 != 3'b000);
    end else begin
      c.ill = 1'b1;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_ev         = 1'b0;
    m_ctl        = '{alu: 4'b0010, src: 1'b1, br: 1'b0, ill: 1'b0};
    m_rv         = 1'b0;
    m_rpc        = 32'd0;
    m_flush_left = 0;
    m_brc        = 32'd0;
    m_tkc        = 32'd0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_ev));
    chk("ALUoperation", 32'(bus.ALUoperation), 32'(m_ctl.alu));
    chk("ALUSrc", 32'(bus.ALUSrc), 32'(m_ctl.src));
    chk("Branch", 32'(bus.Branch), 32'(m_ctl.br));
    chk("illegal", 32'(bus.illegal), 32'(m_ctl.ill));
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
    chk("redirect_pc", bus.redirect_pc, m_rpc);
    chk("flush", 32'(bus.flush), 32'(m_flush_left > 0));
    chk("dbg_state", 32'(dbg_state), 32'(m_flush_left > 0));
`ifdef EX_BRANCH_STATS_EN
    chk("br_count", bus.br_count, m_brc);
    chk("br_taken_count", bus.br_taken_count, m_tkc);
`endif
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns 1 time unit after the next one.
  task automatic cycle(input logic iv, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic mr, input logic bs, input logic [31:0] s);
    logic exp_ready;
    logic acc;
    logic ret;
    logic tk;
    bus.id_valid    = iv;
    bus.id_opcode   = op;
    bus.id_funct3   = f3;
    bus.id_funct7_5 = f7;
    bus.mem_ready   = mr;
    bus.b_sel       = bs;
    bus.sum         = s;
    @(negedge clk);
    exp_ready = (m_flush_left > 0) || !m_ev || mr;
    chk("id_ready", 32'(bus.id_ready), 32'(exp_ready));
    @(posedge clk);
    acc = iv && exp_ready;
    ret = m_ev && mr;
    tk  = (m_flush_left == 0) && ret && m_ctl.br && bs;
    if (ret && m_ctl.br) begin
      m_brc++;
      if (bs) m_tkc++;
    end
    m_rv = tk;
    if (tk) m_rpc = s;
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (tk) begin
      m_ev         = 1'b0;
      m_flush_left = FC;
    end else if (acc) begin
      m_ev  = 1'b1;
      m_ctl = ref_decode(op, f3, f7);
    end else if (ret) begin
      m_ev = 1'b0;
    end
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.id_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- test ----------------
  dec_vec_t tbl [17];
  logic [6:0] rnd_ops [6];

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    f3_alu   = '{4'b0010, 4'b0010, 4'b0111, 4'b0010, 4'b0011, 4'b0010, 4'b0001, 4'b0000};
    f3_legal = 8'b1101_0101;
    rnd_ops  = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, 7'b1111111};

    tbl[0]  = '{OP_R,      3'b000, 1'b0, '{4'b0010, 1'b1, 1'b0, 1'b0}};
    tbl[1]  = '{OP_R,      3'b000, 1'b1, '{4'b0110, 1'b1, 1'b0, 1'b0}};
    tbl[2]  = '{OP_R,      3'b111, 1'b0, '{4'b0000, 1'b1, 1'b0, 1'b0}};
    tbl[3]  = '{OP_R,      3'b110, 1'b0, '{4'b0001, 1'b1, 1'b0, 1'b0}};
    tbl[4]  = '{OP_R,      3'b100, 1'b0, '{4'b0011, 1'b1, 1'b0, 1'b0}};
    tbl[5]  = '{OP_R,      3'b010, 1'b0, '{4'b0111, 1'b1, 1'b0, 1'b0}};
    tbl[6]  = '{OP_R,      3'b001, 1'b0, '{4'b0010, 1'b1, 1'b0, 1'b1}};
    tbl[7]  = '{OP_I,      3'b000, 1'b1, '{4'b0010, 1'b0, 1'b0, 1'b0}};
    tbl[8]  = '{OP_I,      3'b111, 1'b0, '{4'b0000, 1'b0, 1'b0, 1'b0}};
    tbl[9]  = '{OP_I,      3'b010, 1'b0, '{4'b0111, 1'b0, 1'b0, 1'b0}};
    tbl[10] = '{OP_I,      3'b101, 1'b0, '{4'b0010, 1'b0, 1'b0, 1'b1}};
    tbl[11] = '{OP_LOAD,   3'b010, 1'b0, '{4'b0010, 1'b0, 1'b0, 1'b0}};
    tbl[12] = '{OP_STORE,  3'b010, 1'b0, '{4'b0010, 1'b0, 1'b0, 1'b0}};
    tbl[13] = '{OP_BRANCH, 3'b000, 1'b0, '{4'b0110, 1'b1, 1'b1, 1'b0}};
    tbl[14] = '{OP_BRANCH, 3'b001, 1'b0, '{4'b0110, 1'b1, 1'b1, 1'b1}};
    tbl[15] = '{7'b1111111, 3'b000, 1'b0, '{4'b0010, 1'b1, 1'b0, 1'b1}};
    tbl[16] = '{7'b0110111, 3'b000, 1'b0, '{4'b0010, 1'b1, 1'b0, 1'b1}};

    reset           = 1'b0;
    bus.id_valid    = 1'b0;
    bus.id_opcode   = 7'd0;
    bus.id_funct3   = 3'd0;
    bus.id_funct7_5 = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.b_sel       = 1'b0;
    bus.sum         = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_ALUoperation", 32'(bus.ALUoperation), 32'h2);
    chk("rst_ALUSrc", 32'(bus.ALUSrc), 32'd1);
    chk("rst_Branch", 32'(bus.Branch), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_redirect", 32'(bus.redirect_valid), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    reset = 1'b1;

    // Decode table, back-to-back with mem_ready high
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, tbl[i].op, tbl[i].f3, tbl[i].f7, 1'b1, 1'b0, 32'd0);
      chk("tbl_ex_valid", 32'(bus.ex_valid), 32'd1);
      chk("tbl_alu", 32'(bus.ALUoperation), 32'(tbl[i].exp.alu));
      chk("tbl_src", 32'(bus.ALUSrc), 32'(tbl[i].exp.src));
      chk("tbl_br", 32'(bus.Branch), 32'(tbl[i].exp.br));
      chk("tbl_ill", 32'(bus.illegal), 32'(tbl[i].exp.ill));
    end

    // Taken beq: one redirect pulse, FC flush cycles, FC+1 offers dropped
    cycle(1'b1, OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, OP_I, 3'b000, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
    chk("tk_redirect_valid", 32'(bus.redirect_valid), 32'd1);
    chk("tk_redirect_pc", bus.redirect_pc, 32'h40);
    chk("tk_ex_valid", 32'(bus.ex_valid), 32'd0);
    begin
      int flush_cycles;
      flush_cycles = 0;
      for (int i = 0; i < 4 && bus.flush; i++) begin
        flush_cycles++;
        cycle(1'b1, OP_R, 3'b111, 1'b0, 1'b1, 1'b1, 32'h1234);
        chk("fl_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("fl_ex_valid", 32'(bus.ex_valid), 32'd0);
      end
      chk("flush_len", 32'(flush_cycles), 32'(FC));
    end
    cycle(1'b1, OP_R, 3'b100, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("post_flush_load", 32'(bus.ex_valid), 32'd1);
    chk("post_flush_alu", 32'(bus.ALUoperation), 32'h3);

    // Not-taken beq: next instruction loads without a bubble
    cycle(1'b1, OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, OP_I, 3'b000, 1'b0, 1'b1, 1'b0, 32'h80);
    chk("nt_redirect", 32'(bus.redirect_valid), 32'd0);
    chk("nt_flush", 32'(bus.flush), 32'd0);
    chk("nt_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("nt_alu", 32'(bus.ALUoperation), 32'h2);
    chk("nt_src", 32'(bus.ALUSrc), 32'd0);

    // MEM stall holds EX and blocks ID
    cycle(1'b1, OP_R, 3'b110, 1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, OP_R, 3'b111, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("stall_ready", 32'(bus.id_ready), 32'd0);
      chk("stall_alu", 32'(bus.ALUoperation), 32'h1);
      chk("stall_src", 32'(bus.ALUSrc), 32'd1);
      chk("stall_br", 32'(bus.Branch), 32'd0);
    end
    cycle(1'b1, OP_R, 3'b111, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("unstall_alu", 32'(bus.ALUoperation), 32'h0);

    // Reset asserted mid-flush acts without a clock edge
    cycle(1'b1, OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, OP_I, 3'b000, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
    chk("pre_rst_flush", 32'(bus.flush), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_flush", 32'(bus.flush), 32'd0);
    chk("async_rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("async_rst_redirect", 32'(bus.redirect_valid), 32'd0);
    chk("async_rst_cnt", 32'(dbg_flush_cnt), 32'd0);
    do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            rnd_ops[$urandom_range(0, 5)],
            3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/ex_stage_ctrl.md
Name: ex_stage_ctrl

Overview:
- Control sequencer for the execute stage. Accepts decoded instructions from ID over a valid/ready handshake and holds them in an EX control register.
- Drives the exec stage's ALUoperation, ALUSrc and Branch inputs.
- Resolves taken branches from the exec stage's b_sel/sum and flushes the wrong path for a fixed number of cycles.
- Sits between the ID stage register and the execution stage; the downstream MEM stage is the consumer.

Parameters:
- FLUSH_CYCLES, 2, number of cycles ID input is discarded after a taken branch (range 1..15).

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- id_valid  input  1  ID presents an instruction
- id_ready  output  1  controller accepts the ID instruction this cycle
- id_opcode  input  7  RV32I opcode
- id_funct3  input  3  funct3
- id_funct7_5  input  1  funct7 bit 5
- mem_ready  input  1  downstream accepts the EX instruction
- b_sel  input  1  branch taken from exec stage (Branch AND zero)
- sum  input  32  branch target pc+imm from exec stage
- ex_valid  output  1  EX register holds a live instruction
- ALUoperation  output  4  registered ALU control
- ALUSrc  output  1  registered mux select: 0 = immediate, 1 = reg2
- Branch  output  1  registered branch flag
- illegal  output  1  registered: held opcode not decodable
- redirect_valid  output  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  output  32  registered branch target
- flush  output  1  high while wrong-path instructions are discarded

Behaviour:
Reset (reset=0, asynchronous):
- ex_valid=0, ALUoperation=4'b0010, ALUSrc=1, Branch=0, illegal=0.
- redirect_valid=0, redirect_pc=0, flush=0, state=RUN, flush counter=0.

States:
- RUN, FLUSH.

Handshake:
- Retire = ex_valid && mem_ready.
- id_ready = (state==FLUSH) || !ex_valid || mem_ready.
- Accept = id_valid && id_ready.
- In FLUSH, accepted instructions are consumed and dropped; the EX register is not loaded.

Decode, registered on accept in RUN (codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111):
- 0110011 R-type, ALUSrc=1:
  - f3 000: ADD, or SUB if funct7_5=1
  - f3 111: AND
  - f3 110: OR
  - f3 100: XOR
  - f3 010: SLT
  - other f3: ADD with illegal=1
- 0010011 I-type, ALUSrc=0: same f3 map, but f3 000 is always ADD.
- 0000011 load and 0100011 store: ADD, ALUSrc=0.
- 1100011 branch: SUB, ALUSrc=1, Branch=1. Only f3 000 (beq) is legal; other f3 sets illegal=1.
- Any other opcode: ADD, ALUSrc=1, Branch=0, illegal=1.

Sequencing in RUN:
- Retire with Branch=1 and b_sel=1 (taken):
  - Next cycle: redirect_valid=1 (exactly one cycle), redirect_pc=sum captured at retire, ex_valid=0.
  - state goes to FLUSH, counter=FLUSH_CYCLES, flush=1.
  - An ID instruction accepted in the retire cycle is wrong-path and is dropped.
- Retire without taken branch and Accept in the same cycle: EX loads the new instruction with no bubble.
- Retire without Accept: ex_valid=0 next cycle.
- ex_valid && !mem_ready: all EX outputs hold and id_ready=0.

FLUSH:
- Counter decrements each cycle.
- When the counter reaches 1, the next state is RUN and flush=0. This gives exactly FLUSH_CYCLES cycles with flush=1.
- b_sel is ignored in FLUSH.
- The first accept after FLUSH loads normally.

General:
- b_sel is ignored when Branch=0 or ex_valid=0.
- Reset asserted in any state immediately forces reset values, including mid-FLUSH.

Optional Feature:
- Macro EX_BRANCH_STATS_EN.
- Defined: adds outputs br_count[31:0] and br_taken_count[31:0], both reset to 0.
  - br_count increments on every retire with Branch=1.
  - br_taken_count increments additionally when b_sel=1.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then id_valid with opcode 0110011, f3 000, funct7_5=1, mem_ready=1 → next cycle ex_valid=1, ALUoperation=0110, ALUSrc=1, id_ready stays 1.
- Back-to-back addi (0010011, f3 000) then lw (0000011), mem_ready=1 → consecutive cycles show ALUoperation=0010 and ALUSrc=0, with no bubble.
- beq held, b_sel=1, sum=0x0000_0040 at retire, id_valid=1 continuously → redirect_valid pulses 1 cycle with redirect_pc=0x40, flush=1 for exactly 2 cycles, the 3 offered instructions are dropped, and the 4th is loaded.
- beq with b_sel=0 → no redirect, flush=0, the following instruction is loaded the next cycle.
- mem_ready=0 for 3 cycles with ex_valid=1 → id_ready=0 and ALUoperation/ALUSrc/Branch stable; on mem_ready=1 the pending ID instruction is loaded.
- Opcode 1111111 → illegal=1, ALUoperation=0010. Reset asserted during FLUSH → flush=0, ex_valid=0 immediately, without waiting for a clock edge.
